mdu_multicycle: RTL and testbench
=================================

Name: mdu_multicycle

Overview:
- Parametrised multiply/divide unit for the E stage. It is the successor of the fixed 32-bit MDU.
- Generalised in operand width and in per-class latency. Adds multiply-accumulate/subtract modes, defined divide-by-zero results, a one-cycle Done strobe, and protected HI/LO writes while the unit is busy.
- Sits beside the ALU. The hazard unit stalls on Busy or on a Start presented in the same cycle.

Parameters:
- WIDTH, 32, operand and HI/LO width; legal values are 8 or greater.
- MULT_CYCLES, 5, cycles from Start to HI/LO update for mult/madd/msub; legal values are 1 or greater.
- DIV_CYCLES, 10, cycles from Start to HI/LO update for div/divu; legal values are 1 or greater.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- Req  input  1  interrupt/exception request; while high, blocks new Start and mthi/mtlo
- MDUOp  input  4  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu; 11-15 behave as none
- D1  input  WIDTH  rs operand (dividend / mthi-mtlo source)
- D2  input  WIDTH  rt operand (divisor)
- Start  input  1  launch request for ops 1-4 and 7-10
- Busy  output  1  operation in flight
- Done  output  1  one-cycle pulse, high in the cycle after HI/LO commit
- HI  output  WIDTH  HI register
- LO  output  WIDTH  LO register

Behaviour:
- Reset (synchronous, highest priority):
  - Busy=0, Done=0, HI=0, LO=0; counter and operand latches cleared.
  - Reset mid-operation aborts the operation; no commit happens.
- States:
  - IDLE: counter is 0.
  - RUN: counter is greater than 0.
- Accept condition: Start=1, Req=0, state IDLE, MDUOp in {1-4, 7-10}. An accepted Start latches MDUOp, D1 and D2, loads the counter with MULT_CYCLES or DIV_CYCLES, and sets Busy=1 at that edge.
- Ignored Start: Start is ignored while Busy, while Req=1, or when MDUOp is not a launching op. No error flag is raised.
- RUN counting: the counter decrements each edge. At the edge where the counter equals 1, HI/LO commit, Busy clears, and Done goes to 1 for exactly one cycle.
- Latency: for a Start accepted at edge t0, Busy is high over edges t0..t0+LAT-1. HI/LO become visible after edge t0+LAT. Back-to-back issue is possible: a new Start can be accepted at the commit edge only if Busy is already low, so the earliest next accept is edge t0+LAT+1.
- Req during RUN: does not freeze or abort the in-flight operation. It commits on schedule, because the instruction that issued it has already retired past E.
- mthi/mtlo:
  - With Req=0 and Busy=0, writes D1 into HI or LO at the edge.
  - Ignored while Busy=1 or Req=1.
  - Start is irrelevant to these ops.
- Arithmetic (operands latched at accept; 2*WIDTH product):
  - mult/multu: {HI,LO} = signed or unsigned D1*D2.
  - madd(u): {HI,LO} = {HI,LO} + P.
  - msub(u): {HI,LO} = {HI,LO} - P.
  - For madd/msub, {HI,LO} is the value at the commit edge. It is unchanged since accept because writes are blocked while Busy. Accumulation wraps modulo 2^(2*WIDTH).
  - div: LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend.
  - divu: the unsigned equivalents.
- Division boundary cases:
  - Divide by zero (D2 == 0, both div and divu): LO = all ones, HI = D1. The latency is unchanged.
  - Signed overflow (D1 = most negative, D2 = -1): LO = D1, HI = 0.
- Outputs are registered. No combinational path runs from any input to Busy, Done, HI or LO.

Test Plan:
- Timing and Done (WIDTH=32, MULT_CYCLES=5): multu with D1=0xFFFFFFFF, D2=2 -> Busy is high for exactly 5 cycles, then HI=0x00000001 and LO=0xFFFFFFFE. Done pulses for one cycle after the commit.
- Signed divide and divide by zero: div with D1=-7, D2=2 -> after 10 cycles, LO=0xFFFFFFFD and HI=0xFFFFFFFF. divu with D1=0x1234, D2=0 -> LO=0xFFFFFFFF and HI=0x1234.
- Accumulate: mthi 0, mtlo 0xFFFFFFFF, then maddu 1*1 -> HI=1, LO=0. Then msub with D1=-1, D2=1 -> HI=1, LO=1.
- Blocked writes: during Busy, mthi with D1=0xAAAA and a second Start are both ignored, and the original result commits. mtlo with Req=1 leaves LO unchanged.
- Req and reset mid-operation: mult 3*4 with Req held high for cycles 2-3 -> LO=12 on schedule. Reset asserted at cycle 3 of a div -> Busy=0, HI=LO=0, and no Done pulse.
- Parametrisation: WIDTH=16, MULT_CYCLES=1 -> mult of 0x8000 by 0x8000 gives HI=0x4000 and LO=0x0000 one cycle after Start. Signed divide of 0x8000 by 0xFFFF gives LO=0x8000 and HI=0.

Source files
------------

// File: rtl/mdu_multicycle.sv
// Multi-cycle multiply/divide unit for the E stage.
// Accepts one mult/div/madd/msub operation at a time. It latches the operands at accept,
// counts down a fixed per-class latency, and then commits {HI,LO}. HI/LO writes (mthi/mtlo)
// and new launches are blocked while an operation is in flight or while Req is high.
// Ports:
//   clk, reset     rising-edge clock, synchronous active-high reset
//   Req            interrupt/exception request; blocks new Start and mthi/mtlo
//   MDUOp          operation code (see Op* constants)
//   D1, D2         rs / rt operands
//   Start          launch request for mult/div/madd/msub ops
//   Busy           operation in flight
//   Done           one-cycle pulse in the cycle after the HI/LO commit
//   HI, LO         result registers
module mdu_multicycle #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Req,
  input  logic [3:0]       MDUOp,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  input  logic             Start,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;
  localparam logic [3:0] OpMadd  = 4'd7;
  localparam logic [3:0] OpMaddu = 4'd8;
  localparam logic [3:0] OpMsub  = 4'd9;
  localparam logic [3:0] OpMsubu = 4'd10;

  localparam int unsigned CntMax = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e             state_q;
  logic [CntW-1:0]    cnt_q;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;

  logic               is_launch;
  logic               is_div_in;
  logic [CntW-1:0]    cnt_load;

  logic               op_signed;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod, hilo, result;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;

  // Launch decode on the live inputs.
  always_comb begin
    is_launch = 1'b0;
    is_div_in = 1'b0;
    unique case (MDUOp)
      OpMult, OpMultu, OpMadd, OpMaddu, OpMsub, OpMsubu: is_launch = 1'b1;
      OpDiv, OpDivu: begin
        is_launch = 1'b1;
        is_div_in = 1'b1;
      end
      default: ;
    endcase
    cnt_load = is_div_in ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
  end

  // Result datapath, driven only by latched operands and the current HI/LO.
  always_comb begin
    op_signed = (op_q == OpMult) || (op_q == OpDiv) || (op_q == OpMadd) || (op_q == OpMsub);
    a_ext = op_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    b_ext = op_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    // Sign-extended operands make one 2W-bit wrapping multiply serve both signednesses.
    prod  = a_ext * b_ext;
    hilo  = {HI, LO};

    // Signed divide via magnitudes. The most-negative dividend keeps its bit pattern under
    // negation, which read unsigned is the right magnitude, so MIN / -1 yields LO=MIN, HI=0.
    a_neg  = op_signed & a_q[WIDTH-1];
    b_neg  = op_signed & b_q[WIDTH-1];
    a_mag  = a_neg ? -a_q : a_q;
    b_mag  = b_neg ? -b_q : b_q;
    b_safe = (b_q == '0) ? WIDTH'(1) : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quo    = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem    = a_neg ? -r_mag : r_mag;

    result = hilo;
    unique case (op_q)
      OpMult, OpMultu: result = prod;
      OpMadd, OpMaddu: result = hilo + prod;
      OpMsub, OpMsubu: result = hilo - prod;
      OpDiv, OpDivu:   result = (b_q == '0) ? {a_q, {WIDTH{1'b1}}} : {rem, quo};
      default:         result = hilo;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      HI      <= '0;
      LO      <= '0;
    end else begin
      Done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (Start && !Req && is_launch) begin
            op_q    <= MDUOp;
            a_q     <= D1;
            b_q     <= D2;
            cnt_q   <= cnt_load;
            Busy    <= 1'b1;
            state_q <= StRun;
          end else if (!Req && MDUOp == OpMthi) begin
            HI <= D1;
          end else if (!Req && MDUOp == OpMtlo) begin
            LO <= D1;
          end
        end
        StRun: begin
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            {HI, LO} <= result;
            Busy     <= 1'b0;
            Done     <= 1'b1;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_multicycle.sv
module tb_mdu_multicycle;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, start;
  logic [3:0]  op;
  logic [31:0] d1, d2;
  logic        busy, done;
  logic [31:0] hi, lo;

  logic        req16, start16;
  logic [3:0]  op16;
  logic [15:0] a16, b16;
  logic        busy16, done16;
  logic [15:0] hi16, lo16;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt32 = 0;
  int push_cnt32 = 0;
  logic [63:0] q32[$];
  logic [31:0] q16[$];
  logic [63:0] model_hilo;

  always #5 clk = ~clk;

  mdu_multicycle #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut32 (
    .clk(clk), .reset(reset), .Req(req), .MDUOp(op), .D1(d1), .D2(d2), .Start(start),
    .Busy(busy), .Done(done), .HI(hi), .LO(lo)
  );

  mdu_multicycle #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(2)) u_dut16 (
    .clk(clk), .reset(reset), .Req(req16), .MDUOp(op16), .D1(a16), .D2(b16), .Start(start16),
    .Busy(busy16), .Done(done16), .HI(hi16), .LO(lo16)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboards: every Done pops one expected {HI,LO}.
  always @(negedge clk) begin
    if (done) begin
      done_cnt32++;
      if (q32.size() == 0) chk("done32_unexpected", 64'd1, 64'd0);
      else chk("hilo32", {hi, lo}, q32.pop_front());
    end
    if (done16) begin
      if (q16.size() == 0) chk("done16_unexpected", 64'd1, 64'd0);
      else chk("hilo16", {32'd0, hi16, lo16}, {32'd0, q16.pop_front()});
    end
  end

  // Reference model for the 32-bit unit, built on 64-bit native arithmetic.
  function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] acc);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] ua, ub;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      4'd1:  return sa * sb;
      4'd2:  return ua * ub;
      4'd7:  return acc + 64'(sa * sb);
      4'd8:  return acc + ua * ub;
      4'd9:  return acc - 64'(sa * sb);
      4'd10: return acc - ua * ub;
      4'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      4'd4: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      default: return acc;
    endcase
  endfunction

  // Launch one op, hold Req high over busy cycles rf..rt, and check the busy length.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input int lat, input int rf, input int rt);
    int n;
    q32.push_back(exp);
    push_cnt32++;
    model_hilo = exp;
    @(negedge clk);
    op = o; d1 = a; d2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      req = (n >= rf && n <= rt);
      @(negedge clk);
    end
    req = 1'b0;
    chk("busy_cycles", 64'(n), 64'(lat));
  endtask

  task automatic mt(input logic [3:0] o, input logic [31:0] v);
    @(negedge clk);
    op = o; d1 = v;
    @(negedge clk);
    op = 4'd0;
    if (o == 4'd5) model_hilo[63:32] = v;
    else model_hilo[31:0] = v;
  endtask

  task automatic issue16(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp, input int lat);
    int n;
    q16.push_back(exp);
    @(negedge clk);
    op16 = o; a16 = a; b16 = b; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0; op16 = 4'd0;
    n = 0;
    while (busy16 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("busy16_cycles", 64'(n), 64'(lat));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [3:0] ops [8];
    logic [3:0] o;
    logic [31:0] a, b;
    int n;
    ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd9, 4'd10};

    reset = 1'b1; req = 1'b0; start = 1'b0; op = 4'd0; d1 = '0; d2 = '0;
    req16 = 1'b0; start16 = 1'b0; op16 = 4'd0; a16 = '0; b16 = '0;
    model_hilo = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);

    // 16-bit instance: single-cycle multiply and the signed-overflow divide.
    issue16(4'd1, 16'h8000, 16'h8000, 32'h4000_0000, 1);
    issue16(4'd3, 16'h8000, 16'hFFFF, 32'h0000_8000, 2);

    issue(4'd2, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE, 5, 0, 0);
    issue(4'd3, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 10, 0, 0);
    issue(4'd4, 32'h0000_1234, 32'd0, 64'h0000_1234_FFFF_FFFF, 10, 0, 0);
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 10, 0, 0);

    // Accumulate.
    mt(4'd5, 32'd0);
    mt(4'd6, 32'hFFFF_FFFF);
    chk("mthi_mtlo", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
    issue(4'd8, 32'd1, 32'd1, 64'h0000_0001_0000_0000, 5, 0, 0);
    issue(4'd9, 32'hFFFF_FFFF, 32'd1, 64'h0000_0001_0000_0001, 5, 0, 0);

    // mthi and a second Start while busy are both ignored.
    q32.push_back(64'h0000_0001_0000_002B);
    push_cnt32++;
    model_hilo = 64'h0000_0001_0000_002B;
    @(negedge clk);
    op = 4'd7; d1 = 32'd6; d2 = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 4'd5; d1 = 32'h0000_AAAA;
    @(negedge clk);
    op = 4'd1; d1 = 32'd100; d2 = 32'd100; start = 1'b1;
    @(negedge clk);
    op = 4'd0; start = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("blocked_busy_cycles", 64'(n), 64'd3);
    @(negedge clk);
    chk("blocked_no_relaunch", 64'(busy), 64'd0);

    // mtlo under Req.
    req = 1'b1; op = 4'd6; d1 = 32'h5555;
    @(negedge clk);
    op = 4'd0; req = 1'b0;
    chk("mtlo_req_blocked", {32'd0, lo}, 64'h2B);

    // Req mid-operation does not disturb the commit.
    issue(4'd1, 32'd3, 32'd4, 64'd12, 5, 2, 3);

    // Reset mid-divide: no commit and no Done.
    @(negedge clk);
    op = 4'd3; d1 = 32'd100; d2 = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_hilo = '0;
    chk("midreset_busy", 64'(busy), 64'd0);
    chk("midreset_hilo", {hi, lo}, 64'd0);
    repeat (12) @(negedge clk);
    chk("midreset_done_count", 64'(done_cnt32), 64'(push_cnt32));

    // Random mix checked against the model.
    for (int i = 0; i < 12; i++) begin
      o = ops[$urandom_range(0, 7)];
      a = $urandom();
      b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
      if (i == 5) a = 32'h8000_0000;
      issue(o, a, b, model(o, a, b, model_hilo),
            (o == 4'd3 || o == 4'd4) ? 10 : 5, 0, 0);
    end

    repeat (3) @(negedge clk);
    chk("final_done_count", 64'(done_cnt32), 64'(push_cnt32));
    chk("q32_drained", 64'(q32.size()), 64'd0);
    chk("q16_drained", 64'(q16.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
